rcn_uart: RTL and testbench
===========================

Name: rcn_uart

Overview:
- 8N1 UART slave attached to the rcn ring; one ring stage between a neighbouring rcn_in/rcn_out pair, e.g. inserted between the test-register and sram_0 stages.
- Consumes rcn requests whose address falls in its window and replaces each one in the same ring slot with its response.
- Drives uart_tx and samples uart_rx through small TX/RX FIFOs.
- All other ring traffic is forwarded unchanged after one register delay.

Parameters:
- ADDR_MASK, 22'h3FFFF0, address bits compared for a hit.
- ADDR_BASE, 22'h3FFFE0, window base (byte address).
- BAUD_DIV, 16'd434, reset value of the baud divisor in clocks per bit (50 MHz / 115200).
- FIFO_AW, 2, log2 of the depth of each FIFO (depth 4).

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- rcn_in, input, 67, ring input.
- rcn_out, output, 67, ring output (registered).
- uart_rx, input, 1, serial input (asynchronous).
- uart_tx, output, 1, serial output (registered).

Behaviour:
- rcn field map:
  - [66] vld; [65] req (1 = request, 0 = response); [64] wr.
  - [63:58] master id; [57:54] byte mask.
  - [53:32] byte address; [31:0] data.
- Hit: vld & req & ((addr & ADDR_MASK) == ADDR_BASE).
- Ring stage:
  - rcn_out <= rcn_in every cycle, except on a hit.
  - On a hit, rcn_out <= response: vld=1, req=0; wr, id, mask and addr copied; data = read data for reads, written data echoed for writes.
  - Latency is exactly 1 cycle. There is no back-pressure and no extra slot is consumed.
- Register select is addr[3:2]:
  - 0 DATA:
    - Write with mask[0]=1 pushes data[7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and tx_ovf is set.
    - Read pops the RX FIFO and returns {23'b0, 1'b1, byte}. If the RX FIFO is empty, it returns 0 and pops nothing.
  - 1 STATUS:
    - Read bit map: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] rx_ovr, [5] tx_busy, [6] frame_err, [7] tx_ovf; all other bits 0.
    - Write with mask[0]=1: a 1 clears the corresponding sticky bit among 4, 6 and 7.
  - 2 BAUD: read/write bits [15:0], honouring mask[1:0]. A written value below 16 is clamped to 16. A new value takes effect at the next bit boundary.
  - 3: reads 0; writes are ignored.
- TX engine states: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state or bit lasts BAUD clocks.
  - IDLE pops the FIFO when it is not empty and enters START on the next cycle.
  - tx_busy = 1 whenever the state is not IDLE.
  - Back-to-back bytes leave no idle bit between STOP and the next START beyond the 1-cycle pop.
- RX engine:
  - uart_rx passes through a 2-flop synchronizer.
  - States: IDLE -> START -> DATA -> STOP.
  - A falling edge in IDLE starts a BAUD/2 count.
  - At the midpoint, if the line is high again the start is false; return to IDLE with no flags.
  - Otherwise, sample 8 bits at BAUD intervals, then the stop bit.
  - Stop high: push the byte. If the RX FIFO is full, drop the byte and set rx_ovr.
  - Stop low: drop the byte, set frame_err, and wait for the line to go high before returning to IDLE.
- Simultaneous events:
  - An RX push and a bus pop in the same cycle are both honoured. The popped byte is the oldest; on a full FIFO with a simultaneous pop, the push succeeds.
  - A TX pop and a bus push in the same cycle are handled the same way.
  - The STATUS value read is the value before that cycle's updates.
- FIFO pointers are FIFO_AW+1 bits wide and wrap naturally. full/empty are derived from the MSB comparison.
- Reset values:
  - rcn_out = 0; uart_tx = 1.
  - FIFOs empty; BAUD = BAUD_DIV; all sticky bits 0.
  - Both engines in IDLE.
- Reset asserted mid-frame aborts immediately: uart_tx = 1 and partial bytes are discarded.

Test Plan:
1. Reset, then read STATUS at 0x3FFFE4 -> response data 0x00000006, id/addr echoed, 1 cycle after the request.
2. Write 0x55 to DATA -> uart_tx low for 434 clks, then bits 1,0,1,0,1,0,1,0 at 434 clks each, then high for 434; tx_busy reads 1 mid-frame.
3. Drive 0xA3 8N1 at 434 clks/bit on uart_rx, then read DATA -> 0x000001A3; a second read -> 0x00000000.
4. Receive 5 bytes without reading -> rx_full=1 and rx_ovr=1; reads return bytes 1-4 in order; writing 0x10 to STATUS clears rx_ovr.
5. Send a byte with stop bit 0 -> frame_err set and FIFO unchanged. Separately, a 0.3-bit low glitch -> no flags and no byte.
6. Send a request to 0x3E0010 and a response packet with addr 0x3FFFE0 -> both forwarded unchanged with 1-cycle delay. Assert rst mid-TX -> uart_tx=1 immediately and STATUS=0x06 after release.

Source files
------------

// File: rtl/rcn_uart.sv
// ============================================================================
//  Module      : rcn_uart
//  Description : 8N1 UART slave on the rcn ring. Requests in the address
//                window are replaced in-slot by their response; all other
//                traffic passes through one register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rcn_uart #(
  parameter logic [21:0] ADDR_MASK = 22'h3FFFF0,
  parameter logic [21:0] ADDR_BASE = 22'h3FFFE0,
  parameter logic [15:0] BAUD_DIV  = 16'd434,
  parameter int          FIFO_AW   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [66:0] rcn_in,
  output logic [66:0] rcn_out,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // Bus decode
  logic        hit, bus_wr, wr_m0, wr_m1;
  logic [1:0]  sel;
  logic [31:0] bus_data, rd_data, rsp_data;
  assign hit      = rcn_in[66] & rcn_in[65] & ((rcn_in[53:32] & ADDR_MASK) == ADDR_BASE);
  assign bus_wr   = rcn_in[64];
  assign wr_m0    = rcn_in[54];
  assign wr_m1    = rcn_in[55];
  assign sel      = rcn_in[35:34];
  assign bus_data = rcn_in[31:0];

  // FIFO storage and pointers
  logic [7:0]       tx_mem [DEPTH];
  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                    (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                    (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);

  // Control/status registers
  logic [15:0] baud, baud_wr_val, baud_clamped;
  logic        rx_ovr, frame_err, tx_ovf;

  // Engine state
  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_meta, rx_sync;
  logic        tx_busy;
  assign tx_busy = (tx_state != TX_IDLE);

  // FIFO traffic; a pop in the same cycle frees the slot for a push into a full FIFO
  logic tx_pop, tx_push_req, tx_push, rx_pop, rx_stop_pt, rx_done_ok, rx_frame_bad, rx_push;
  assign tx_pop       = (tx_state == TX_IDLE) & ~tx_empty;
  assign tx_push_req  = hit & bus_wr & (sel == 2'd0) & wr_m0;
  assign tx_push      = tx_push_req & (~tx_full | tx_pop);
  assign rx_pop       = hit & ~bus_wr & (sel == 2'd0) & ~rx_empty;
  assign rx_stop_pt   = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
  assign rx_done_ok   = rx_stop_pt & rx_sync;
  assign rx_frame_bad = rx_stop_pt & ~rx_sync;
  assign rx_push      = rx_done_ok & (~rx_full | rx_pop);

  assign baud_wr_val  = {wr_m1 ? bus_data[15:8] : baud[15:8], wr_m0 ? bus_data[7:0] : baud[7:0]};
  assign baud_clamped = (baud_wr_val < 16'd16) ? 16'd16 : baud_wr_val;

  // Read mux reflects state before this cycle's updates
  always_comb begin
    rd_data = 32'd0;
    case (sel)
      2'd0: rd_data = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_mem[rx_rp[FIFO_AW-1:0]]};
      2'd1: rd_data = {24'd0, tx_ovf, frame_err, tx_busy, rx_ovr,
                       rx_full, rx_empty, tx_empty, tx_full};
      2'd2: rd_data = {16'd0, baud};
      default: rd_data = 32'd0;
    endcase
  end
  assign rsp_data = bus_wr ? bus_data : rd_data;

  // Ring stage, pointers, baud register and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcn_out   <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      baud      <= BAUD_DIV;
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      rcn_out <= hit ? {1'b1, 1'b0, rcn_in[64:32], rsp_data} : rcn_in;
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      if (hit && bus_wr && sel == 2'd2 && (wr_m0 || wr_m1)) baud <= baud_clamped;
      if (hit && bus_wr && sel == 2'd1 && wr_m0) begin
        if (bus_data[4]) rx_ovr    <= 1'b0;
        if (bus_data[6]) frame_err <= 1'b0;
        if (bus_data[7]) tx_ovf    <= 1'b0;
      end
      if (rx_done_ok && rx_full && !rx_pop)     rx_ovr    <= 1'b1;
      if (rx_frame_bad)                         frame_err <= 1'b1;
      if (tx_push_req && tx_full && !tx_pop)    tx_ovf    <= 1'b1;
    end
  end

  // FIFO memory writes (contents need no reset)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= bus_data[7:0];
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
  end

  // TX engine: each state/bit holds for baud clocks, baud latched at each boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'd0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (!tx_empty) begin
            tx_sh    <= tx_mem[tx_rp[FIFO_AW-1:0]];
            tx_cnt   <= baud - 16'd1;
            tx_state <= TX_START;
            uart_tx  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= baud - 16'd1;
            tx_bit   <= 3'd0;
            uart_tx  <= tx_sh[0];
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        TX_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= baud - 16'd1;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              tx_sh   <= {1'b0, tx_sh[7:1]};
              uart_tx <= tx_sh[1];
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        default: begin
          if (tx_cnt == 16'd0) tx_state <= TX_IDLE;
          else                 tx_cnt   <= tx_cnt - 16'd1;
        end
      endcase
    end
  end

  // RX engine: synchronize, validate start at half bit, sample mid-bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'd0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= (baud >> 1) - 16'd1;
          end
        end
        RX_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_sync) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              rx_cnt   <= baud - 16'd1;
              rx_bit   <= 3'd0;
            end
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        RX_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_sh  <= {rx_sync, rx_sh[7:1]};
            rx_cnt <= baud - 16'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        RX_STOP: begin
          if (rx_cnt == 16'd0) rx_state <= rx_sync ? RX_IDLE : RX_BREAK;
          else                 rx_cnt   <= rx_cnt - 16'd1;
        end
        default: begin
          if (rx_sync) rx_state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rcn_uart.sv
// ============================================================================
//  Module      : tb_rcn_uart
//  Description : Self-checking bench for rcn_uart (scoreboard of ring
//                responses plus serial-line checks).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rcn_uart;

  localparam int BAUD = 434;
  localparam logic [21:0] A_DATA = 22'h3FFFE0;
  localparam logic [21:0] A_STAT = 22'h3FFFE4;
  localparam logic [21:0] A_BAUD = 22'h3FFFE8;
  localparam logic [21:0] A_RSV  = 22'h3FFFEC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [66:0] rcn_in = '0;
  logic [66:0] rcn_out;
  logic        uart_rx = 1'b1;
  logic        uart_tx;

  always #5 clk = ~clk;

  rcn_uart dut (
    .clk     (clk),
    .rst     (rst),
    .rcn_in  (rcn_in),
    .rcn_out (rcn_out),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  typedef struct {
    logic [66:0] val;
    int          due;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [5:0] id_ctr = 6'h01;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Ring monitor: every expected word must appear exactly on its due cycle
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rcn_out", rcn_out, e.val);
    end else if (rcn_out[66]) begin
      check("rcn_out_spurious", rcn_out, 67'd0);
    end
  end

  // Issue one request (caller sits on a negedge); response expected next cycle
  task automatic bus(input logic wr, input logic [21:0] addr, input logic [3:0] mask,
                     input logic [31:0] data, input logic [31:0] rdata);
    logic [66:0] req;
    exp_t        e;
    req    = {1'b1, 1'b1, wr, id_ctr, mask, addr, data};
    id_ctr = id_ctr + 6'd1;
    e.val  = {1'b1, 1'b0, req[64:32], (wr ? data : rdata)};
    e.due  = cyc + 1;
    sb.push_back(e);
    rcn_in = req;
    @(negedge clk);
    rcn_in = '0;
  endtask

  // Non-hit traffic: expected to come out untouched one cycle later
  task automatic raw(input logic [66:0] w);
    exp_t e;
    e.val = w;
    e.due = cyc + 1;
    sb.push_back(e);
    rcn_in = w;
    @(negedge clk);
    rcn_in = '0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BAUD) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // Watch one TX frame: find the start edge, then sample mid-bit and around the first boundary
  task automatic tx_expect(input logic [7:0] b);
    logic [9:0] frame;
    logic       seen;
    frame = {1'b1, b, 1'b0};
    seen  = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (uart_tx == 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    check("tx_start_seen", 67'(seen), 67'(1));
    if (seen) begin
      for (int k = 0; k < 10 * BAUD; k++) begin
        if (k % BAUD == BAUD / 2 || k == BAUD - 1 || k == BAUD)
          check($sformatf("tx_line_k%0d", k), 67'(uart_tx), 67'(frame[k / BAUD]));
        @(negedge clk);
      end
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : main
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (3) @(negedge clk);
    check("rst_rcn_out", rcn_out, 67'd0);
    check("rst_uart_tx", 67'(uart_tx), 67'(1));
    rst = 1'b0;
    @(negedge clk);

    // Reset-state register reads
    bus(1'b0, A_STAT, 4'hF, 32'h0, 32'h0000_0006);
    bus(1'b0, A_BAUD, 4'hF, 32'h0, 32'd434);
    bus(1'b0, A_RSV,  4'hF, 32'h0, 32'h0);

    // Transmit 0x55 and observe busy mid-frame
    bus(1'b1, A_DATA, 4'h1, 32'h0000_0055, 32'h0);
    fork
      tx_expect(8'h55);
      begin
        repeat (100) @(negedge clk);
        bus(1'b0, A_STAT, 4'hF, 32'h0, 32'h0000_0026);
      end
    join
    bus(1'b0, A_STAT, 4'hF, 32'h0, 32'h0000_0006);

    // Receive one byte, then empty read
    rx_send(8'hA3, 1'b1);
    repeat (5) @(negedge clk);
    bus(1'b0, A_DATA, 4'hF, 32'h0, 32'h0000_01A3);
    bus(1'b0, A_DATA, 4'hF, 32'h0, 32'h0);

    // Overrun: five bytes into a four-deep FIFO
    for (int i = 0; i < 5; i++) rx_send(bytes[i], 1'b1);
    repeat (5) @(negedge clk);
    bus(1'b0, A_STAT, 4'hF, 32'h0, 32'h0000_001A);
    for (int i = 0; i < 4; i++) bus(1'b0, A_DATA, 4'hF, 32'h0, {23'd0, 1'b1, bytes[i]});
    bus(1'b1, A_STAT, 4'h1, 32'h0000_0010, 32'h0);
    bus(1'b0, A_STAT, 4'hF, 32'h0, 32'h0000_0006);

    // Framing error, then clear it
    rx_send(8'h5C, 1'b0);
    repeat (BAUD) @(negedge clk);
    bus(1'b0, A_STAT, 4'hF, 32'h0, 32'h0000_0046);
    bus(1'b0, A_DATA, 4'hF, 32'h0, 32'h0);
    bus(1'b1, A_STAT, 4'h1, 32'h0000_0040, 32'h0);

    // Short low glitch: no byte, no flags
    uart_rx = 1'b0;
    repeat (130) @(negedge clk);
    uart_rx = 1'b1;
    repeat (600) @(negedge clk);
    bus(1'b0, A_STAT, 4'hF, 32'h0, 32'h0000_0006);
    bus(1'b0, A_DATA, 4'hF, 32'h0, 32'h0);

    // Baud register: clamp and byte-mask handling
    bus(1'b1, A_BAUD, 4'h3, 32'h0000_0005, 32'h0);
    bus(1'b0, A_BAUD, 4'hF, 32'h0, 32'd16);
    bus(1'b1, A_BAUD, 4'h3, 32'd434, 32'h0);
    bus(1'b1, A_BAUD, 4'h1, 32'hFFFF_FF20, 32'h0);
    bus(1'b0, A_BAUD, 4'hF, 32'h0, 32'h0000_0120);
    bus(1'b1, A_BAUD, 4'h3, 32'd434, 32'h0);
    bus(1'b0, A_BAUD, 4'hF, 32'h0, 32'd434);

    // Pass-through traffic
    raw({1'b1, 1'b1, 1'b0, 6'h2A, 4'hF, 22'h3E0010, 32'hDEAD_BEEF});
    raw({1'b1, 1'b0, 1'b1, 6'h05, 4'hF, A_DATA, 32'h1234_5678});

    // TX overflow: six back-to-back writes
    for (int i = 0; i < 6; i++) bus(1'b1, A_DATA, 4'h1, 32'h0000_00C0 + 32'(i), 32'h0);
    bus(1'b0, A_STAT, 4'hF, 32'h0, 32'h0000_00A5);

    // Reset in the middle of the start bit
    repeat (50) @(negedge clk);
    check("tx_low_before_rst", 67'(uart_tx), 67'(0));
    rst = 1'b1;
    #1;
    check("rst_async_uart_tx", 67'(uart_tx), 67'(1));
    check("rst_async_rcn_out", rcn_out, 67'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus(1'b0, A_STAT, 4'hF, 32'h0, 32'h0000_0006);
    repeat (BAUD * 2) @(negedge clk);
    check("tx_idle_after_rst", 67'(uart_tx), 67'(1));

    repeat (5) @(negedge clk);
    check("sb_drained", 67'(sb.size()), 67'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
